// File: rtl/uart_ctrl_pkg.sv
// Shared constants and types for the buffered UART host controller.
// Covers the CPU-side and UART-side register maps, status bit positions and sequencer states.
package uart_ctrl_pkg;

  // CPU-side register map
  localparam logic [3:0] CpuAddrRx    = 4'd0;
  localparam logic [3:0] CpuAddrTx    = 4'd1;
  localparam logic [3:0] CpuAddrStat  = 4'd2;
  localparam logic [3:0] CpuAddrIe    = 4'd3;
  localparam logic [3:0] CpuAddrDivLo = 4'd4;
  localparam logic [3:0] CpuAddrDivHi = 4'd5;

  // UART-side register map
  localparam logic [3:0] UartAddrData  = 4'd0;
  localparam logic [3:0] UartAddrTx    = 4'd1;
  localparam logic [3:0] UartAddrStat  = 4'd2;
  localparam logic [3:0] UartAddrDivLo = 4'd4;
  localparam logic [3:0] UartAddrDivHi = 4'd5;

  // CPU status register bits
  localparam int unsigned StatRxNonempty = 0;
  localparam int unsigned StatRxFull     = 1;
  localparam int unsigned StatTxEmpty    = 2;
  localparam int unsigned StatTxFull     = 3;
  localparam int unsigned StatTxOvf      = 6;
  localparam int unsigned StatRxOvr      = 7;

  // UART status register bits
  localparam int unsigned UStatTxDone  = 0;
  localparam int unsigned UStatRxReady = 1;

  typedef enum logic [2:0] {
    StIdle,
    StPoll,
    StRx,
    StTx,
    StXclr,
    StDivLo,
    StDivHi
  } seq_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Byte-wide synchronous FIFO with head-of-queue visibility.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCnt = DEPTH[AW:0];

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FullCnt);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: contents are only visible through the count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// Host-side UART controller: CPU-visible TX/RX FIFOs plus a sequencer that polls
// the UART status, moves bytes and pushes divisor updates over the UART register bus.
module uart_fifo_ctrl #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned DIV_RESET = 43
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] io_addr,
  input  logic [7:0] io_wdata,
  input  logic       io_write,
  input  logic       io_read,
  output logic [7:0] io_rdata,
  output logic       interrupt,
  output logic [3:0] u_addr,
  output logic [7:0] u_wdata,
  output logic       u_write,
  output logic       u_read,
  input  logic [7:0] u_rdata,
  input  logic       u_interrupt
);
  import uart_ctrl_pkg::*;

  seq_state_e  state_q, state_d;
  logic        tx_busy_q, tx_busy_d;
  logic        div_pend_q, div_pend_d;
  logic [1:0]  ie_q, ie_d;
  logic        rx_ovr_q, rx_ovr_d;
  logic        tx_ovf_q, tx_ovf_d;
  logic [11:0] div_q, div_d;

  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0] rx_head, tx_head, status;
  logic       div_wr;

  assign rx_push = (state_q == StRx);
  assign rx_pop  = io_read && (io_addr == CpuAddrRx);
  assign tx_push = io_write && (io_addr == CpuAddrTx);
  assign tx_pop  = (state_q == StTx);
  assign div_wr  = io_write && ((io_addr == CpuAddrDivLo) || (io_addr == CpuAddrDivHi));

  sync_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk  (clk),
    .reset(reset),
    .push (rx_push),
    .wdata(u_rdata),
    .pop  (rx_pop),
    .head (rx_head),
    .full (rx_full),
    .empty(rx_empty)
  );

  sync_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk  (clk),
    .reset(reset),
    .push (tx_push),
    .wdata(io_wdata),
    .pop  (tx_pop),
    .head (tx_head),
    .full (tx_full),
    .empty(tx_empty)
  );

  always_comb begin
    state_d   = state_q;
    tx_busy_d = tx_busy_q;
    case (state_q)
      StIdle: begin
        if (div_pend_q)                  state_d = StDivLo;
        else if (u_interrupt)            state_d = StPoll;
        else if (!tx_busy_q && !tx_empty) state_d = StTx;
      end
      StPoll: begin
        if (u_rdata[UStatTxDone]) tx_busy_d = 1'b0;
        if (u_rdata[UStatRxReady])                state_d = StRx;
        else if (u_rdata[UStatTxDone] && tx_empty) state_d = StXclr;
        else                                      state_d = StIdle;
      end
      StTx: begin
        tx_busy_d = 1'b1;
        state_d   = StIdle;
      end
      StDivLo: state_d = StDivHi;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ie_d       = ie_q;
    div_d      = div_q;
    rx_ovr_d   = rx_ovr_q;
    tx_ovf_d   = tx_ovf_q;
    div_pend_d = div_pend_q;
    if (io_write) begin
      case (io_addr)
        CpuAddrStat: begin
          if (io_wdata[7]) rx_ovr_d = 1'b0;
          if (io_wdata[6]) tx_ovf_d = 1'b0;
        end
        CpuAddrIe:    ie_d        = io_wdata[1:0];
        CpuAddrDivLo: div_d[7:0]  = io_wdata;
        CpuAddrDivHi: div_d[11:8] = io_wdata[3:0];
        default: ;
      endcase
    end
    // A new overflow event wins over a simultaneous clear.
    if (rx_push && rx_full && !rx_pop) rx_ovr_d = 1'b1;
    if (tx_push && tx_full && !tx_pop) tx_ovf_d = 1'b1;
    if (state_q == StDivHi) div_pend_d = 1'b0;
    if (div_wr)             div_pend_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      tx_busy_q  <= 1'b0;
      div_pend_q <= 1'b0;
      ie_q       <= 2'b00;
      rx_ovr_q   <= 1'b0;
      tx_ovf_q   <= 1'b0;
      div_q      <= DIV_RESET[11:0];
    end else begin
      state_q    <= state_d;
      tx_busy_q  <= tx_busy_d;
      div_pend_q <= div_pend_d;
      ie_q       <= ie_d;
      rx_ovr_q   <= rx_ovr_d;
      tx_ovf_q   <= tx_ovf_d;
      div_q      <= div_d;
    end
  end

  always_comb begin
    u_addr  = 4'd0;
    u_wdata = 8'h00;
    u_write = 1'b0;
    u_read  = 1'b0;
    case (state_q)
      StPoll:  begin u_read  = 1'b1; u_addr = UartAddrStat; end
      StRx:    begin u_read  = 1'b1; u_addr = UartAddrData; end
      StTx:    begin u_write = 1'b1; u_addr = UartAddrTx;    u_wdata = tx_head;             end
      StXclr:  begin u_write = 1'b1; u_addr = UartAddrStat;  u_wdata = 8'h01;               end
      StDivLo: begin u_write = 1'b1; u_addr = UartAddrDivLo; u_wdata = div_q[7:0];          end
      StDivHi: begin u_write = 1'b1; u_addr = UartAddrDivHi; u_wdata = {4'h0, div_q[11:8]}; end
      default: ;
    endcase
  end

  always_comb begin
    status                 = 8'h00;
    status[StatRxNonempty] = ~rx_empty;
    status[StatRxFull]     = rx_full;
    status[StatTxEmpty]    = tx_empty;
    status[StatTxFull]     = tx_full;
    status[StatTxOvf]      = tx_ovf_q;
    status[StatRxOvr]      = rx_ovr_q;
  end

  always_comb begin
    case (io_addr)
      CpuAddrRx:    io_rdata = rx_empty ? 8'h00 : rx_head;
      CpuAddrStat:  io_rdata = status;
      CpuAddrIe:    io_rdata = {6'b0, ie_q};
      CpuAddrDivLo: io_rdata = div_q[7:0];
      CpuAddrDivHi: io_rdata = {4'h0, div_q[11:8]};
      default:      io_rdata = 8'h00;
    endcase
  end

  assign interrupt = (ie_q[0] & ~rx_empty) | (ie_q[1] & tx_empty) | rx_ovr_q | tx_ovf_q;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed bench for uart_fifo_ctrl with a small UART register model.
// The model clears tx-done when its status is read or when 0x01 is written to its status.
module tb_uart_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] io_addr = 4'd0;
  logic [7:0] io_wdata = 8'h00;
  logic       io_write = 1'b0;
  logic       io_read = 1'b0;
  logic [7:0] io_rdata;
  logic       interrupt;
  logic [3:0] u_addr;
  logic [7:0] u_wdata;
  logic       u_write, u_read;
  logic [7:0] u_rdata;
  logic       u_interrupt;

  uart_fifo_ctrl #(.DEPTH(8), .DIV_RESET(43)) dut (
    .clk        (clk),
    .reset      (reset),
    .io_addr    (io_addr),
    .io_wdata   (io_wdata),
    .io_write   (io_write),
    .io_read    (io_read),
    .io_rdata   (io_rdata),
    .interrupt  (interrupt),
    .u_addr     (u_addr),
    .u_wdata    (u_wdata),
    .u_write    (u_write),
    .u_read     (u_read),
    .u_rdata    (u_rdata),
    .u_interrupt(u_interrupt)
  );

  always #5 clk = ~clk;

  // UART model
  logic       m_tx_done, m_rx_ready, m_hold = 1'b0, inj = 1'b0;
  logic [7:0] m_rx_data, inj_data = 8'h00;
  int         m_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_tx_done  <= 1'b0;
      m_rx_ready <= 1'b0;
      m_rx_data  <= 8'h00;
      m_cnt      <= 0;
    end else begin
      if (u_write && u_addr == 4'd1) m_cnt <= 3;
      else if (m_cnt > 0 && !m_hold) m_cnt <= m_cnt - 1;
      if (u_read && u_addr == 4'd2) m_tx_done <= 1'b0;
      if (u_write && u_addr == 4'd2 && u_wdata[0]) m_tx_done <= 1'b0;
      if (m_cnt == 1 && !m_hold && !(u_write && u_addr == 4'd1)) m_tx_done <= 1'b1;
      if (u_read && u_addr == 4'd0) m_rx_ready <= 1'b0;
      if (inj) begin
        m_rx_ready <= 1'b1;
        m_rx_data  <= inj_data;
      end
    end
  end

  assign u_rdata     = (u_addr == 4'd2) ? {6'b0, m_rx_ready, m_tx_done} :
                       (u_addr == 4'd0) ? m_rx_data : 8'h00;
  assign u_interrupt = m_tx_done | m_rx_ready;

  // Bus log: {kind(1=write,2=read), addr, data}
  logic [15:0] log_q[$];
  logic [15:0] wr_q[$];
  logic        prev_w = 1'b0, prev_r = 1'b0;
  logic [3:0]  prev_addr = 4'd0;
  int          width_viol = 0;

  always @(negedge clk) begin
    if (u_write) log_q.push_back({4'h1, u_addr, u_wdata});
    if (u_read)  log_q.push_back({4'h2, u_addr, u_rdata});
    if (((u_write && prev_w) || (u_read && prev_r)) && u_addr == prev_addr)
      width_viol <= width_viol + 1;
    prev_w    <= u_write;
    prev_r    <= u_read;
    prev_addr <= u_addr;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    io_addr = a; io_wdata = d; io_write = 1'b1;
    @(posedge clk);
    #1 io_write = 1'b0;
  endtask

  task automatic cpu_read(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    io_addr = a; io_read = 1'b1;
    #1 d = io_rdata;
    @(posedge clk);
    #1 io_read = 1'b0;
  endtask

  task automatic peek(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    io_addr = a;
    #1 d = io_rdata;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic deliver(input logic [7:0] b, input string tag);
    bit done = 1'b0;
    @(negedge clk); inj = 1'b1; inj_data = b;
    @(negedge clk); inj = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (!m_rx_ready) done = 1'b1;
      else @(negedge clk);
    end
    check_val(tag, 16'(done), 16'd1);
  endtask

  task automatic collect_writes(input int from);
    wr_q.delete();
    for (int i = from; i < log_q.size(); i++)
      if (log_q[i][15:12] == 4'h1) wr_q.push_back(log_q[i]);
  endtask

  function automatic logic [15:0] wr_at(int idx);
    if (idx < wr_q.size()) return wr_q[idx];
    return 16'hFFFF;
  endfunction

  function automatic logic [15:0] log_at(int idx);
    if (idx < log_q.size()) return log_q[idx];
    return 16'hFFFF;
  endfunction

  // Count addr-1 writes (after the first `skip`) not preceded by a status read showing tx-done.
  function automatic int unpolled(int from, int skip);
    logic [15:0] last_rd = 16'hFFFF;
    int nw = 0, bad = 0;
    for (int i = from; i < log_q.size(); i++) begin
      if (log_q[i][15:12] == 4'h2) last_rd = log_q[i];
      else if (log_q[i][11:8] == 4'h1) begin
        if (nw >= skip && !(last_rd[11:8] == 4'h2 && last_rd[0])) bad++;
        nw++;
      end
    end
    return bad;
  endfunction

  initial begin
    logic [7:0] d;
    int base;
    bit seen;

    // Reset state
    cycles(3);
    #1 check_val("rst_outs", {3'b0, interrupt, u_write, u_read, u_addr, u_wdata}, 16'h0000);
    @(negedge clk) reset = 1'b0;
    peek(4'd2, d); check_val("rst_status", d, 8'h04);
    peek(4'd4, d); check_val("rst_div_lo", d, 8'h2B);
    peek(4'd5, d); check_val("rst_div_hi", d, 8'h00);
    peek(4'd3, d); check_val("rst_ie", d, 8'h00);
    peek(4'd0, d); check_val("rst_rx_empty", d, 8'h00);

    // TX burst
    base = log_q.size();
    cpu_write(4'd1, 8'h55);
    @(negedge clk); check_val("tx_lat_idle", {3'b0, u_write, u_addr, u_wdata}, 16'h0000);
    @(negedge clk); check_val("tx_lat_write", {3'b0, u_write, u_addr, u_wdata}, 16'h1155);
    cpu_write(4'd1, 8'hA3);
    cpu_write(4'd1, 8'h0F);
    cycles(60);
    collect_writes(base);
    check_val("burst_nwr", 16'(wr_q.size()), 16'd4);
    check_val("burst_w0", wr_at(0), 16'h1155);
    check_val("burst_w1", wr_at(1), 16'h11A3);
    check_val("burst_w2", wr_at(2), 16'h110F);
    check_val("burst_xclr", wr_at(3), 16'h1201);
    check_val("burst_polled", 16'(unpolled(base, 1)), 16'd0);

    // RX single byte with rx interrupt enabled
    cpu_write(4'd3, 8'h01);
    peek(4'd3, d); check_val("ie_readback", d, 8'h01);
    #1 check_val("irq_rx_idle", 16'(interrupt), 16'd0);
    base = log_q.size();
    deliver(8'h3C, "rx_consumed");
    check_val("rx_nlog", 16'(log_q.size() - base), 16'd2);
    check_val("rx_poll", log_at(base), 16'h2202);
    check_val("rx_read", log_at(base + 1), 16'h203C);
    peek(4'd2, d); check_val("rx_status", d, 8'h05);
    #1 check_val("irq_rx", 16'(interrupt), 16'd1);
    cpu_read(4'd0, d); check_val("rx_data", d, 8'h3C);
    peek(4'd2, d); check_val("rx_status_after", d, 8'h04);
    #1 check_val("irq_rx_clr", 16'(interrupt), 16'd0);
    cpu_write(4'd3, 8'h00);

    // RX overrun
    for (int i = 0; i < 9; i++) deliver(8'h10 + 8'(i), $sformatf("ovr_consumed%0d", i));
    peek(4'd2, d); check_val("ovr_status", d, 8'h87);
    #1 check_val("ovr_irq", 16'(interrupt), 16'd1);
    cpu_write(4'd2, 8'h80);
    peek(4'd2, d); check_val("ovr_cleared", d, 8'h07);
    #1 check_val("ovr_irq_clr", 16'(interrupt), 16'd0);
    for (int i = 0; i < 8; i++) begin
      cpu_read(4'd0, d);
      check_val($sformatf("ovr_data%0d", i), d, 8'h10 + 8'(i));
    end
    peek(4'd2, d); check_val("ovr_drained", d, 8'h04);

    // TX overflow while busy, then order across pointer wrap
    m_hold = 1'b1;
    cpu_write(4'd1, 8'h60);
    cycles(10);
    for (int i = 1; i <= 9; i++) cpu_write(4'd1, 8'h60 + 8'(i));
    peek(4'd2, d); check_val("ovf_status", d, 8'h48);
    #1 check_val("ovf_irq", 16'(interrupt), 16'd1);
    cpu_write(4'd2, 8'h40);
    peek(4'd2, d); check_val("ovf_cleared", d, 8'h08);
    base = log_q.size();
    m_hold = 1'b0;
    cycles(120);
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 5; k++) cpu_write(4'd1, 8'h70 + 8'(5 * g + k));
      cycles(80);
    end
    wr_q.delete();
    for (int i = base; i < log_q.size(); i++)
      if (log_q[i][15:8] == 8'h11) wr_q.push_back(log_q[i]);
    check_val("wrap_count", 16'(wr_q.size()), 16'd28);
    for (int i = 0; i < 28; i++)
      check_val($sformatf("wrap_byte%0d", i), wr_at(i),
                {8'h11, (i < 8) ? 8'h61 + 8'(i) : 8'h70 + 8'(i - 8)});
    check_val("wrap_polled", 16'(unpolled(base, 0)), 16'd0);

    // Divisor update ahead of a pending TX
    m_hold = 1'b1;
    cpu_write(4'd1, 8'h90);
    cycles(10);
    cpu_write(4'd1, 8'h91);
    cycles(3);
    base = log_q.size();
    cpu_write(4'd4, 8'h10);
    cpu_write(4'd5, 8'h02);
    cycles(10);
    m_hold = 1'b0;
    cycles(40);
    collect_writes(base);
    check_val("div_nwr", 16'(wr_q.size()), 16'd4);
    check_val("div_lo_wr", wr_at(0), 16'h1410);
    check_val("div_hi_wr", wr_at(1), 16'h1502);
    check_val("div_then_tx", wr_at(2), 16'h1191);
    check_val("div_xclr", wr_at(3), 16'h1201);
    peek(4'd4, d); check_val("div_lo_rd", d, 8'h10);
    peek(4'd5, d); check_val("div_hi_rd", d, 8'h02);

    // Divisor write landing during DIV_HI re-arms the update
    base = log_q.size();
    cpu_write(4'd4, 8'h21);
    cycles(2);
    cpu_write(4'd5, 8'h03);
    cycles(20);
    collect_writes(base);
    check_val("rearm_nwr", 16'(wr_q.size()), 16'd4);
    check_val("rearm_w0", wr_at(0), 16'h1421);
    check_val("rearm_w1", wr_at(1), 16'h1502);
    check_val("rearm_w2", wr_at(2), 16'h1421);
    check_val("rearm_w3", wr_at(3), 16'h1503);

    // Async reset in the RX state with TX bytes queued
    m_hold = 1'b1;
    cpu_write(4'd1, 8'hA0);
    cycles(10);
    cpu_write(4'd1, 8'hA1);
    cpu_write(4'd1, 8'hA2);
    cpu_write(4'd1, 8'hA3);
    cpu_write(4'd3, 8'h03);
    @(negedge clk); inj = 1'b1; inj_data = 8'h77;
    @(negedge clk); inj = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (u_read && u_addr == 4'd0) seen = 1'b1;
      else @(negedge clk);
    end
    check_val("mid_rx_reached", 16'(seen), 16'd1);
    reset = 1'b1;
    #1;
    check_val("mid_rst_strobes", {14'b0, u_write, u_read}, 16'h0000);
    check_val("mid_rst_bus", {4'b0, u_addr, u_wdata}, 16'h0000);
    check_val("mid_rst_irq", 16'(interrupt), 16'd0);
    m_hold = 1'b0;
    cycles(2);
    @(negedge clk) reset = 1'b0;
    base = log_q.size();
    peek(4'd2, d); check_val("mid_status", d, 8'h04);
    peek(4'd3, d); check_val("mid_ie", d, 8'h00);
    cycles(20);
    collect_writes(base);
    check_val("mid_no_tx", 16'(wr_q.size()), 16'd0);

    check_val("strobe_width", 16'(width_viol), 16'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
